seg_disp_scan: RTL and testbench
================================

SEG_DISP_SCAN -- requirements
Module: seg_disp_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles each digit stays lit; legal range 32..2^20.
REQ-002 SHALL have parameter SEG_ACT_LOW, default 1, meaning 1 for active-low seg/com outputs and 0 for active-high.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL provide port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL provide port hi_val, input, 7 bits: left counter value (qout of upstream 0..99 counter), binary.
REQ-007 SHALL provide port lo_val, input, 7 bits: right counter value, binary.
REQ-008 SHALL provide port dp_on, input, 1 bit: colon/decimal-point request for digit 2.
REQ-009 SHALL provide port seg, output, 8 bits: segments {dp,g,f,e,d,c,b,a}, registered.
REQ-010 SHALL provide port com, output, 4 bits: digit enables, bit 3 = leftmost, registered, one-hot when lit.

Function
REQ-011 SHALL count clk cycles in prescaler 0..SCAN_DIV-1, asserting an internal tick at SCAN_DIV-1 and wrapping to 0.
REQ-012 SHALL advance 2-bit digit index on each tick, order 3→2→1→0→3, wrapping.
REQ-013 SHALL, on the tick that moves the index to 3 (frame start), latch hi_val and lo_val into snapshot registers and start the converter.
REQ-014 SHALL saturate snapshot values > 99 to 99 before conversion.
REQ-015 SHALL implement converter FSM states IDLE→CONV_HI→CONV_LO→DONE→IDLE.
REQ-016 SHALL, in CONV_HI/CONV_LO, subtract 10 from a working register and increment the tens count each cycle while the working value ≥ 10, then take the remainder as ones and move to the next state.
REQ-017 SHALL hold worst-case conversion at 22 cycles, which is below 32 ≤ SCAN_DIV, so the result is always ready before digit 3 is driven again.
REQ-018 SHALL, in DONE, copy all four BCD digits into the display registers in one cycle, so no frame shows mixed old/new digits.
REQ-019 SHALL ignore a frame-start event arriving while the FSM is not IDLE; this case is unreachable for legal SCAN_DIV.
REQ-020 SHALL map digits as: index3 = hi tens, index2 = hi ones, index1 = lo tens, index0 = lo ones.
REQ-021 SHALL decode BCD 0..9 to standard 7-segment patterns; codes 10..15 SHALL show all segments off.
REQ-022 SHALL drive dp active only when index = 2 and dp_on = 1; dp_on is sampled each cycle.
REQ-023 SHALL register seg and com together one cycle after the index change, so they always switch in the same cycle.
REQ-024 SHALL invert seg and com polarity when SEG_ACT_LOW = 1.
REQ-025 SHALL light only digit 3 in the first cycle of each new frame, with no ghosting cycle where two com bits are active.

Reset
REQ-026 SHALL clear, on rst = 1 at a clk edge: prescaler = 0, index = 3, FSM = IDLE, snapshots = 0, display BCD = 0.
REQ-027 SHALL drive seg and com to their inactive level during rst (all 1 when active-low), then display "00 00" after release.
REQ-028 SHALL abort any conversion on rst asserted mid-conversion, with no partial digits reaching the display.
REQ-029 SHALL perform the first snapshot/conversion on the first frame-start tick after reset release.

Structure
REQ-030 SHALL place the 7-segment pattern constants, FSM state encodings and the value 99 saturation limit in shared package watch_pkg.
REQ-031 SHALL implement the sequential ÷10 converter as sub-module bin2bcd_seq (inputs: start and 7-bit value; outputs: busy, done, tens, ones), instantiated once and reused for hi then lo.

Verification (SCAN_DIV = 32, SEG_ACT_LOW = 1)
REQ-032 SHALL check: hold rst 3 cycles → seg = 8'hFF and com = 4'hF during reset; after release, com sequence 0111,1011,1101,1110 every 32 cycles with seg = 0xC0 (digit "0").
REQ-033 SHALL check: hi_val = 59, lo_val = 7 before frame start → next frame digits 5,9,0,7 (seg 0x92,0x90,0xC0,0xF8).
REQ-034 SHALL check: hi_val = 120, lo_val = 99 → displays 9,9,9,9 (saturation).
REQ-035 SHALL check: hi_val changes 23→24 while index = 1 → current frame keeps 2,3; next frame shows 2,4.
REQ-036 SHALL check: dp_on = 1 → seg bit 7 low only while com = 1011; dp_on = 0 → bit 7 always high.
REQ-037 SHALL check: rst pulsed during CONV_HI with hi_val = 88 → outputs inactive during rst, display shows 00 00 until the next full conversion completes.

Source files
------------

// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the two-counter 7-segment scan display:
//   - converter FSM state encoding
//   - saturation limit applied to the counter snapshots
//   - 7-segment patterns, active-high, bit order {g,f,e,d,c,b,a}
//   - helpers: BCD-to-segment decode and saturation to 0..99
// -----------------------------------------------------------------------------
package watch_pkg;

    // Largest value a two-digit display can show.
    localparam logic [6:0] SAT_LIMIT = 7'd99;

    // Divisor used by the sequential binary-to-BCD converter.
    localparam logic [6:0] DIV_TEN = 7'd10;

    // Converter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONV_HI = 2'd1,
        ST_CONV_LO = 2'd2,
        ST_DONE    = 2'd3
    } conv_state_e;

    // Segment patterns, active-high, {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Decode one BCD digit; the non-decimal codes 10..15 show a blank digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Clamp an upstream counter value into the displayable range.
    function automatic logic [6:0] sat99(input logic [6:0] v);
        return (v > SAT_LIMIT) ? SAT_LIMIT : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter for values 0..99. Each busy cycle
// subtracts ten from the working value and bumps the tens count; once the
// working value drops below ten it is the ones digit and 'done' is raised
// for that cycle. A new 'start' may be issued in the same cycle as 'done',
// which lets one instance convert two values back to back.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset, aborts a running conversion
//   start  in   load 'value' and begin converting (has priority)
//   value  in   7-bit binary value, expected 0..99
//   busy   out  conversion in progress (includes the 'done' cycle)
//   done   out  tens/ones are valid this cycle
//   tens   out  BCD tens digit
//   ones   out  BCD ones digit
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import watch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] value,
    output logic       busy,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] work_q;
    logic [6:0] work_d;
    logic [3:0] tens_q;
    logic [3:0] tens_d;
    logic       busy_q;
    logic       busy_d;

    // Next-state logic: load on start, otherwise repeated subtract-by-ten.
    always_comb begin
        work_d = work_q;
        tens_d = tens_q;
        busy_d = busy_q;
        if (start) begin
            work_d = value;
            tens_d = 4'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (work_q >= DIV_TEN) begin
                work_d = work_q - DIV_TEN;
                tens_d = tens_q + 4'd1;
            end else begin
                busy_d = 1'b0;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Working registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= 7'd0;
            tens_q <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            work_q <= work_d;
            tens_q <= tens_d;
            busy_q <= busy_d;
        end
    end

    // The remainder is below ten when done, so its low nibble is the ones digit.
    assign busy = busy_q;
    assign done = busy_q && (work_q < DIV_TEN);
    assign tens = tens_q;
    assign ones = work_q[3:0];

endmodule

// File: rtl/seg_disp_scan.sv
// -----------------------------------------------------------------------------
// seg_disp_scan
// Multiplexed driver for a 4-digit 7-segment display showing two 0..99
// counters as "HH LL". A prescaler holds each digit lit for SCAN_DIV clocks,
// scanning digit 3 (leftmost) down to digit 0. At each frame start both
// counter values are snapshotted (clamped to 99), converted to BCD by a
// single shared sequential converter, and then copied into the display
// registers in one cycle so a frame never mixes digits from two snapshots.
//
// Parameters
//   SCAN_DIV     clocks each digit stays lit, 32..2^20
//   SEG_ACT_LOW  1: seg/com active-low, 0: active-high
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   hi_val  in   left counter value (binary)
//   lo_val  in   right counter value (binary)
//   dp_on   in   decimal point / colon request for digit 2
//   seg     out  registered segments {dp,g,f,e,d,c,b,a}
//   com     out  registered digit enables, bit 3 = leftmost, one-hot when lit
// -----------------------------------------------------------------------------
module seg_disp_scan
    import watch_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int SEG_ACT_LOW = 1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] hi_val,
    input  logic [6:0] lo_val,
    input  logic       dp_on,
    output logic [7:0] seg,
    output logic [3:0] com
);

    localparam int              CNT_W   = 20;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    // XOR masks turning the active-high internal view into pin polarity.
    // They also equal the "all off" level driven during reset.
    localparam logic [7:0] SEG_INV = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [3:0] COM_INV = (SEG_ACT_LOW != 0) ? 4'hF  : 4'h0;

    // Scan timing.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic             tick_s;
    logic             frame_start_s;

    // Converter sequencing.
    conv_state_e      state_q;
    conv_state_e      state_d;
    logic [6:0]       snap_hi_q;
    logic [6:0]       snap_hi_d;
    logic [6:0]       snap_lo_q;
    logic [6:0]       snap_lo_d;
    logic [3:0]       hi_tens_q;
    logic [3:0]       hi_tens_d;
    logic [3:0]       hi_ones_q;
    logic [3:0]       hi_ones_d;
    logic [3:0]       lo_tens_q;
    logic [3:0]       lo_tens_d;
    logic [3:0]       lo_ones_q;
    logic [3:0]       lo_ones_d;

    // Shared converter handshake.
    logic             conv_start_s;
    logic [6:0]       conv_val_s;
    logic             conv_busy_s;
    logic             conv_done_s;
    logic [3:0]       conv_tens_s;
    logic [3:0]       conv_ones_s;

    // Display digits, indexed by scan position (3 = hi tens ... 0 = lo ones).
    logic [3:0][3:0]  disp_q;
    logic [3:0][3:0]  disp_d;

    // Output stage.
    logic [3:0]       digit_s;
    logic [7:0]       seg_q;
    logic [7:0]       seg_d;
    logic [3:0]       com_q;
    logic [3:0]       com_d;

    // Prescaler and digit index; the index wrapping 0 -> 3 marks a new frame.
    always_comb begin
        tick_s = (cnt_q == CNT_MAX);
        if (tick_s) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q - 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
        frame_start_s = tick_s && (idx_q == 2'd0);
    end

    // Converter FSM: snapshot, convert hi then lo, publish all four digits.
    always_comb begin
        state_d      = state_q;
        snap_hi_d    = snap_hi_q;
        snap_lo_d    = snap_lo_q;
        hi_tens_d    = hi_tens_q;
        hi_ones_d    = hi_ones_q;
        lo_tens_d    = lo_tens_q;
        lo_ones_d    = lo_ones_q;
        disp_d       = disp_q;
        conv_start_s = 1'b0;
        conv_val_s   = 7'd0;
        case (state_q)
            ST_IDLE: begin
                // A frame start seen outside IDLE is simply dropped.
                if (frame_start_s) begin
                    snap_hi_d = sat99(hi_val);
                    snap_lo_d = sat99(lo_val);
                    state_d   = ST_CONV_HI;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CONV_HI: begin
                if (!conv_busy_s) begin
                    // First cycle in this state: kick off the hi conversion.
                    conv_start_s = 1'b1;
                    conv_val_s   = snap_hi_q;
                    state_d      = ST_CONV_HI;
                end else if (conv_done_s) begin
                    // Capture hi and reuse the converter for lo right away.
                    hi_tens_d    = conv_tens_s;
                    hi_ones_d    = conv_ones_s;
                    conv_start_s = 1'b1;
                    conv_val_s   = snap_lo_q;
                    state_d      = ST_CONV_LO;
                end else begin
                    state_d      = ST_CONV_HI;
                end
            end
            ST_CONV_LO: begin
                if (conv_done_s) begin
                    lo_tens_d = conv_tens_s;
                    lo_ones_d = conv_ones_s;
                    state_d   = ST_DONE;
                end else begin
                    state_d   = ST_CONV_LO;
                end
            end
            ST_DONE: begin
                disp_d[3] = hi_tens_q;
                disp_d[2] = hi_ones_q;
                disp_d[1] = lo_tens_q;
                disp_d[0] = lo_ones_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: segments and enable for the digit the index points at.
    always_comb begin
        digit_s = disp_q[idx_q];
        if ((idx_q == 2'd2) && dp_on) begin
            seg_d = {1'b1, bcd_to_seg(digit_s)} ^ SEG_INV;
        end else begin
            seg_d = {1'b0, bcd_to_seg(digit_s)} ^ SEG_INV;
        end
        com_d = (4'b0001 << idx_q) ^ COM_INV;
    end

    // All state registers; reset parks the outputs at their inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= {CNT_W{1'b0}};
            idx_q     <= 2'd3;
            state_q   <= ST_IDLE;
            snap_hi_q <= 7'd0;
            snap_lo_q <= 7'd0;
            hi_tens_q <= 4'd0;
            hi_ones_q <= 4'd0;
            lo_tens_q <= 4'd0;
            lo_ones_q <= 4'd0;
            disp_q    <= 16'h0000;
            seg_q     <= SEG_INV;
            com_q     <= COM_INV;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            snap_hi_q <= snap_hi_d;
            snap_lo_q <= snap_lo_d;
            hi_tens_q <= hi_tens_d;
            hi_ones_q <= hi_ones_d;
            lo_tens_q <= lo_tens_d;
            lo_ones_q <= lo_ones_d;
            disp_q    <= disp_d;
            seg_q     <= seg_d;
            com_q     <= com_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .value (conv_val_s),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .tens  (conv_tens_s),
        .ones  (conv_ones_s)
    );

    assign seg = seg_q;
    assign com = com_q;

endmodule

// File: tb/tb_seg_disp_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_disp_scan
// Self-checking bench for seg_disp_scan with SCAN_DIV = 32, active-low pins.
// The reference model is a cycle counter since reset release plus the four
// digits of the current frame, computed with / and % from the values present
// on the frame-start edge. com and the dp bit are compared every cycle; the
// digit segments are compared on the last cycle of each digit window, by
// which time the new frame's conversion has finished.
// -----------------------------------------------------------------------------
module tb_seg_disp_scan;

    localparam int DIV   = 32;
    localparam int FRAME = 4 * DIV;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [6:0] hi_val = 7'd0;
    logic [6:0] lo_val = 7'd0;
    logic       dp_on  = 1'b0;
    logic [7:0] seg;
    logic [3:0] com;

    int n_vec   = 0;
    int n_bad   = 0;
    int k       = 0;     // edges since reset release
    int exp_dig [4];     // [3]=hi tens, [2]=hi ones, [1]=lo tens, [0]=lo ones
    bit rand_dp = 1'b0;

    always #5 clk = ~clk;

    seg_disp_scan #(
        .SCAN_DIV    (DIV),
        .SEG_ACT_LOW (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .hi_val (hi_val),
        .lo_val (lo_val),
        .dp_on  (dp_on),
        .seg    (seg),
        .com    (com)
    );

    // Standard active-high {g..a} pattern of a decimal digit.
    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] p;
        case (d)
            0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
            4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
            8: p = 7'h7F;  9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got=%h expected=%h", tag, k, got, exp);
        end
    endtask

    // One clock edge with model update and output comparisons.
    task automatic step();
        bit         dp_s;
        bit         snap;
        int         h;
        int         l;
        int         dig;
        logic [3:0] ec;
        logic [6:0] es;
        dp_s = dp_on;
        snap = ((k % FRAME) == FRAME - 1);
        h    = (int'(hi_val) > 99) ? 99 : int'(hi_val);
        l    = (int'(lo_val) > 99) ? 99 : int'(lo_val);
        @(posedge clk);
        #1;
        dig = 3 - ((k / DIV) % 4);
        ec  = ~(4'b0001 << dig);
        chk("com", com, ec);
        chk("dp", seg[7], (dp_s && dig == 2) ? 32'd0 : 32'd1);
        if ((k % DIV) == DIV - 1) begin
            es = ~seg_of(exp_dig[dig]);
            chk("seg", seg[6:0], es);
        end
        if (snap) begin
            exp_dig[3] = h / 10;
            exp_dig[2] = h % 10;
            exp_dig[1] = l / 10;
            exp_dig[0] = l % 10;
        end
        k++;
        if (rand_dp) dp_on = 1'($urandom_range(0, 1));
    endtask

    task automatic run_until(input int kt);
        while (k <= kt) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_seg", seg, 8'hFF);
            chk("rst_com", com, 4'hF);
        end
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 4; i++) exp_dig[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_dig[i] = 0;

        // Reset, then a frame of "00 00" with the scan order checked per cycle.
        do_reset(3);
        run_until(FRAME - 1);

        // 59 / 7 shows up one frame after the snapshot that sees it.
        hi_val = 7'd59;
        lo_val = 7'd7;
        run_until(2 * FRAME - 1);
        run_until(2 * FRAME + DIV - 1);      chk("d59_h10", seg, 8'h92);
        run_until(2 * FRAME + 2 * DIV - 1);  chk("d59_h1",  seg, 8'h90);
        run_until(2 * FRAME + 3 * DIV - 1);  chk("d07_l10", seg, 8'hC0);
        run_until(3 * FRAME - 1);            chk("d07_l1",  seg, 8'hF8);

        // Saturation: 120 clamps to 99.
        hi_val = 7'd120;
        lo_val = 7'd99;
        run_until(4 * FRAME - 1);
        run_until(4 * FRAME + DIV - 1);      chk("sat_h10", seg, 8'h90);
        run_until(5 * FRAME - 1);            chk("sat_l1",  seg, 8'h90);

        // Input change mid-frame only appears in the following frame.
        hi_val = 7'd23;
        lo_val = 7'd45;
        run_until(6 * FRAME - 1);
        run_until(6 * FRAME + 2 * DIV - 1);  chk("mid_old", seg, 8'hB0);
        run_until(6 * FRAME + 2 * DIV + 5);
        hi_val = 7'd24;
        run_until(7 * FRAME - 1);
        run_until(7 * FRAME + DIV - 1);      chk("mid_h10", seg, 8'hA4);
        run_until(7 * FRAME + 2 * DIV - 1);  chk("mid_new", seg, 8'h99);

        // Decimal point held on for a whole frame.
        dp_on = 1'b1;
        run_until(8 * FRAME - 1);
        dp_on = 1'b0;

        // Random values and random per-cycle dp requests.
        rand_dp = 1'b1;
        repeat (6) begin
            hi_val = 7'($urandom_range(0, 127));
            lo_val = 7'($urandom_range(0, 127));
            run_until(k + FRAME - 1);
        end
        rand_dp = 1'b0;
        dp_on   = 1'b0;

        // Reset landing in the middle of converting 88.
        hi_val = 7'd88;
        lo_val = 7'd33;
        run_until(k + FRAME - 1 + 3);
        do_reset(2);
        run_until(DIV - 1);                  chk("abort_00", seg, 8'hC0);
        run_until(FRAME - 1);
        run_until(FRAME + DIV - 1);          chk("post_88",  seg, 8'h80);
        run_until(2 * FRAME - 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
